// File: rtl/regfile_mp_sb_pkg.sv
// regfile_mp_sb_pkg
// Shared constants and helpers for the multi-port register file with
// busy scoreboard. The top-level parameter defaults are taken from here
// so that every user of the register file agrees on one configuration.
package regfile_mp_sb_pkg;

    localparam int          RF_DATA_WIDTH     = 32;
    localparam int          RF_REG_NUM        = 32;
    localparam int          RF_REG_ADDR_WIDTH = 5;
    localparam logic        RF_RST_ENABLE     = 1'b0;   // reset asserted level
    localparam logic        RF_WR_ENABLE      = 1'b1;   // write enable asserted level
    localparam int          RF_REG_ZERO       = 1;      // register 0 hardwired to zero
    localparam logic [31:0] RF_RST_DATA       = 32'h0000_0000;

    // True when a register address names an implemented register. Only
    // matters when REG_NUM is smaller than the address space.
    function automatic logic addr_in_range(input int unsigned addr,
                                           input int unsigned reg_num);
        return addr < reg_num;
    endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// regfile_bypass_mux
// Per-read-port bypass select. Compares one read address against every
// write port; when any enabled write port targets that address the write
// data is forwarded instead of the stored value. With several matching
// ports the highest-index port wins, matching the commit priority of the
// register array.
//
// Ports:
//   rd_addr     - read address of this port
//   wr_en       - per-write-port enable
//   wr_addr     - packed write addresses, port w at [w*ADDR_WIDTH +: ADDR_WIDTH]
//   wr_data     - packed write data, port w at [w*DATA_WIDTH +: DATA_WIDTH]
//   stored_data - value currently held in the register array
//   data        - forwarded or stored value
//   hit         - 1 when some enabled write port targets rd_addr
module regfile_bypass_mux
    import regfile_mp_sb_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_REG_ADDR_WIDTH,
    parameter int WR_PORTS   = 2
) (
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    input  logic [WR_PORTS-1:0]            wr_en,
    input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr,
    input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0]          stored_data,
    output logic [DATA_WIDTH-1:0]          data,
    output logic                           hit
);

    logic [WR_PORTS-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < WR_PORTS; gi++) begin : g_match
            assign match[gi] = (wr_en[gi] == RF_WR_ENABLE) &&
                               (wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr);
        end
    endgenerate

    // Ascending scan: a later (higher-index) match overrides an earlier one.
    always_comb begin
        data = stored_data;
        for (int w = 0; w < WR_PORTS; w++) begin
            if (match[w]) begin
                data = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign hit = |match;

endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
// Multi-port integer register file with write-to-read bypass and a
// per-register busy scoreboard for a dual-issue pipeline with
// out-of-order writeback.
//
// Ports:
//   clk          - core clock, all state updates on rising edge
//   rst_n        - asynchronous active-low reset; clears data and busy bits
//   rd_addr_i    - packed read addresses (RD_PORTS x ADDR_WIDTH)
//   rd_data_o    - packed read data, combinational (RD_PORTS x DATA_WIDTH)
//   rd_busy_o    - per read port: operand still awaiting its producer
//   wr_en_i      - per write port enable
//   wr_addr_i    - packed write addresses (WR_PORTS x ADDR_WIDTH)
//   wr_data_i    - packed write data (WR_PORTS x DATA_WIDTH)
//   alloc_en_i   - issue allocates a destination register
//   alloc_addr_i - register being allocated
//   flush_i      - clears every busy bit
//   busy_vec_o   - registered scoreboard state
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int DATA_WIDTH  = RF_DATA_WIDTH,
    parameter int REG_NUM     = RF_REG_NUM,
    parameter int ADDR_WIDTH  = RF_REG_ADDR_WIDTH,
    parameter int RD_PORTS    = 2,
    parameter int WR_PORTS    = 2,
    parameter int ZERO_REG_EN = RF_REG_ZERO
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data_o,
    output logic [RD_PORTS-1:0]            rd_busy_o,
    input  logic [WR_PORTS-1:0]            wr_en_i,
    input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data_i,
    input  logic                           alloc_en_i,
    input  logic [ADDR_WIDTH-1:0]          alloc_addr_i,
    input  logic                           flush_i,
    output logic [REG_NUM-1:0]             busy_vec_o
);

    localparam logic [DATA_WIDTH-1:0] RST_VALUE = DATA_WIDTH'(RF_RST_DATA);

    logic [DATA_WIDTH-1:0] mem_reg  [REG_NUM];
    logic [DATA_WIDTH-1:0] mem_next [REG_NUM];
    logic [REG_NUM-1:0]    busy_reg;
    logic [REG_NUM-1:0]    busy_next;

    // ------------------------------------------------------------------
    // Register array next state. Ports are applied in ascending order so
    // the highest-index enabled port wins an address collision.
    // ------------------------------------------------------------------
    always_comb begin
        mem_next = mem_reg;
        for (int w = 0; w < WR_PORTS; w++) begin
            if (wr_en_i[w] == RF_WR_ENABLE &&
                addr_in_range(32'(wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH]), REG_NUM)) begin
                mem_next[wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH]] =
                    wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (ZERO_REG_EN != 0) begin
            mem_next[0] = '0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard next state, one bit per register.
    // Priority: flush clears, then alloc sets (the new producer owns the
    // register even if an older producer writes back in the same cycle),
    // then a writeback clears, else hold.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_sb
            logic wr_hit;
            logic alloc_hit;

            always_comb begin
                wr_hit = 1'b0;
                for (int w = 0; w < WR_PORTS; w++) begin
                    if (wr_en_i[w] == RF_WR_ENABLE &&
                        wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(gi)) begin
                        wr_hit = 1'b1;
                    end
                end
            end

            assign alloc_hit = alloc_en_i && (alloc_addr_i == ADDR_WIDTH'(gi));

            if (ZERO_REG_EN != 0 && gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_normal
                assign busy_next[gi] = flush_i   ? 1'b0 :
                                       alloc_hit ? 1'b1 :
                                       wr_hit    ? 1'b0 :
                                                   busy_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_NUM; r++) begin
                mem_reg[r] <= RST_VALUE;
            end
            busy_reg <= '0;
        end else begin
            mem_reg  <= mem_next;
            busy_reg <= busy_next;
        end
    end

    assign busy_vec_o = busy_reg;

    // ------------------------------------------------------------------
    // Read ports. Out-of-range addresses read as zero and never busy.
    // A same-cycle writeback makes the operand ready via the bypass, so
    // the hit flag masks the busy bit.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] addr;
            logic                  valid;
            logic                  is_zero;
            logic [DATA_WIDTH-1:0] stored;
            logic [DATA_WIDTH-1:0] byp_data;
            logic                  byp_hit;

            assign addr    = rd_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign valid   = addr_in_range(32'(addr), REG_NUM);
            assign is_zero = (ZERO_REG_EN != 0) && (addr == '0);
            assign stored  = valid ? mem_reg[addr] : '0;

            regfile_bypass_mux #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .WR_PORTS   (WR_PORTS)
            ) u_bypass (
                .rd_addr     (addr),
                .wr_en       (wr_en_i),
                .wr_addr     (wr_addr_i),
                .wr_data     (wr_data_i),
                .stored_data (stored),
                .data        (byp_data),
                .hit         (byp_hit)
            );

            assign rd_data_o[gi*DATA_WIDTH +: DATA_WIDTH] =
                (!rst_n || is_zero || !valid) ? '0 : byp_data;
            assign rd_busy_o[gi] = rst_n && valid && busy_reg[addr] && !byp_hit;
        end
    endgenerate

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file for the TinyRISC-V core, the successor to the single-write/two-read register file. Provides RD_PORTS combinational read ports and WR_PORTS prioritised write ports with full write-to-read bypass. Adds a per-register busy scoreboard (set at issue, cleared at writeback, bulk-cleared on flush) for the dual-issue/out-of-order-writeback pipeline. Sits between decode/issue (reads, busy check, alloc) and writeback (writes).

Parameters:
DATA_WIDTH, 32, register width in bits
REG_NUM, 32, number of architectural registers
ADDR_WIDTH, 5, register address width; must satisfy 2**ADDR_WIDTH >= REG_NUM
RD_PORTS, 2, number of read ports (1..4)
WR_PORTS, 2, number of write ports (1..3)
ZERO_REG_EN, 1, 1 = register 0 hardwired to zero; 0 = register 0 is an ordinary register

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rd_addr_i  input  RD_PORTS*ADDR_WIDTH  read addresses, port p in slice [p*ADDR_WIDTH +: ADDR_WIDTH]
rd_data_o  output  RD_PORTS*DATA_WIDTH  read data, port p in slice [p*DATA_WIDTH +: DATA_WIDTH]
rd_busy_o  output  RD_PORTS  1 = operand at port p not yet available
wr_en_i  input  WR_PORTS  per-port write enable
wr_addr_i  input  WR_PORTS*ADDR_WIDTH  write addresses
wr_data_i  input  WR_PORTS*DATA_WIDTH  write data
alloc_en_i  input  1  issue allocates a destination register
alloc_addr_i  input  ADDR_WIDTH  register being allocated
flush_i  input  1  pipeline flush; clears all busy bits
busy_vec_o  output  REG_NUM  raw scoreboard state, registered

Behaviour:
- Reset (rst_n low, asynchronous): every register <= 0, every busy bit <= 0. While rst_n is low, rd_data_o = 0, rd_busy_o = 0, busy_vec_o = 0. Leaving reset mid-operation does not restore any prior state.
- Reads are combinational, zero latency. For port p, in priority order:
  1. reset active -> 0.
  2. ZERO_REG_EN=1 and addr==0 -> 0.
  3. Any wr_en_i[w] with wr_addr==addr -> that wr_data (bypass). If several ports match, the highest index w wins.
  4. Otherwise the stored value.
- Address >= REG_NUM (only possible when REG_NUM < 2**ADDR_WIDTH): read returns 0 and busy 0; write and alloc are ignored.
- Writes take effect on the rising edge. Write ports to different addresses all commit in the same cycle. On an address collision, the highest-index enabled port commits. With ZERO_REG_EN=1, writes to register 0 are dropped.
- Scoreboard update, next state of busy[r] on each edge:
  - flush_i=1 -> 0 for all r. Flush beats alloc and write.
  - Otherwise, alloc_en_i and alloc_addr_i==r -> 1. Alloc beats a same-cycle write to r, because the new producer owns r.
  - Otherwise, any wr_en_i[w] with wr_addr==r -> 0.
  - Otherwise hold.
  - busy[0] is never set when ZERO_REG_EN=1.
- rd_busy_o[p] = busy[addr_p] & ~(any enabled write to addr_p this cycle). A writeback in the current cycle makes the operand ready through the bypass. An alloc in the current cycle does not affect rd_busy_o until the next cycle.
- Write data is stored regardless of busy state; no check is made that a write was allocated.
- No internal FSM beyond the register array and scoreboard. Combinational read paths must have no loops.

Decomposition:
- The shared defines file holds DATA_WIDTH, REG_NUM, REG_ADDR_WIDTH, RST_ENABLE, WR_ENABLE, REG_ZERO and RST_DATA; parameter defaults take these values.
- One sub-module, regfile_bypass_mux. It takes one read address, the write-port vectors and the stored value, and returns the data and a hit flag using a highest-index-wins priority select. It is instantiated RD_PORTS times through a generate loop.
- The scoreboard lives in the top module; it is too small to justify its own sub-module.

Test Plan:
- Reset: hold rst_n low, drive rd_addr=5 and write 0x1234 to register 5 -> rd_data 0 and busy_vec 0. Release reset, read register 5 -> 0x00000000.
- Dual write plus bypass: cycle 1, port0 writes reg3=0xAAAA0000 and port1 writes reg7=0x0000BBBB; same cycle, read ports on 3 and 7 -> 0xAAAA0000 and 0x0000BBBB (bypass). Next cycle with no writes -> same values from storage.
- Write collision: port0 and port1 both write reg9 (0x11, 0x22) -> same-cycle read gives 0x22, next cycle stored 0x22.
- Zero register: write reg0=0xFFFFFFFF and alloc reg0 -> read reg0 = 0, busy_vec[0] = 0. Repeat with ZERO_REG_EN=0 -> read 0xFFFFFFFF next cycle.
- Scoreboard: alloc reg4 -> busy_vec[4]=1 next cycle and rd_busy=1 on port reading reg4. Writeback reg4=0x55 -> in that cycle rd_busy=0 and rd_data=0x55; next cycle busy_vec[4]=0. Alloc and write reg4 in the same cycle -> busy_vec[4] stays 1.
- Flush: alloc regs 1, 2 and 3 over three cycles, then flush_i together with alloc reg6 -> busy_vec all 0 next cycle. Assert rst_n low mid-sequence -> busy_vec and register contents clear immediately, without waiting for a clock edge.
